// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, error codes, common command bytes.
package ps2_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACKW,
    ST_DONE,
    ST_ERR
  } ps2_tx_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_START_TO = 2'd1;
  localparam logic [1:0] ERR_XFER_TO  = 2'd2;
  localparam logic [1:0] ERR_NACK     = 2'd3;

  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;

  localparam int unsigned CNT_W = 21;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioner: 2-FF synchronizer, FILT_LEN-sample glitch filter and
// one-cycle falling-edge pulse. Used by both the receive and transmit paths.
module ps2_line_sync #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic fe_o
);

  localparam int unsigned FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          meta_q;
  logic          sync_q;
  logic          level_q;
  logic          fe_q;
  logic [FW-1:0] run_q;

  // run_q counts consecutive samples that disagree with the accepted level;
  // the FILT_LEN-th such sample flips the level.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      fe_q    <= 1'b0;
      run_q   <= '0;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      fe_q   <= 1'b0;
      if (sync_q == level_q) begin
        run_q <= '0;
      end else if (run_q == FW'(FILT_LEN - 1)) begin
        level_q <= sync_q;
        run_q   <= '0;
        fe_q    <= ~sync_q;
      end else begin
        run_q <= run_q + FW'(1);
      end
    end
  end

  assign level_o = level_q;
  assign fe_o    = fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (open-drain line enables).
// Optional build macro PS2_HOST_TX_RETRY_EN: retry transfer timeouts and NACKs up to twice.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYC  = 12_000,
  parameter int unsigned START_TO_CYC = 1_500_000,
  parameter int unsigned XFER_TO_CYC  = 200_000,
  parameter int unsigned FILT_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code
);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TO_CYC - 1);
  localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TO_CYC - 1);

  ps2_tx_state_e    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_sat;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       byte_q;
  logic             par_q;
  logic             clk_oe_q;
  logic             data_oe_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [1:0]       code_q;
  logic             fail_d;
  logic [1:0]       fail_code_d;
  logic             retry_ok;
  logic             clk_lvl;
  logic             clk_fe;
  logic             data_lvl;
  logic             data_fe_unused;
`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0]       retry_q;
`endif

  ps2_line_sync #(.FILT_LEN(FILT_LEN)) u_clk_sync (
    .clk     (clk),
    .rst_ni  (rst),
    .line_i  (ps2_clk_in),
    .level_o (clk_lvl),
    .fe_o    (clk_fe)
  );

  ps2_line_sync #(.FILT_LEN(FILT_LEN)) u_data_sync (
    .clk     (clk),
    .rst_ni  (rst),
    .line_i  (ps2_data_in),
    .level_o (data_lvl),
    .fe_o    (data_fe_unused)
  );

  assign cnt_sat = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // Timeouts are evaluated ahead of any edge so a coincident fe loses to them.
  always_comb begin
    fail_d      = 1'b0;
    fail_code_d = ERR_NONE;
    unique case (state_q)
      ST_REQ: if (cnt_q == START_LAST) begin
        fail_d      = 1'b1;
        fail_code_d = ERR_START_TO;
      end
      ST_DATA, ST_PARITY, ST_ACKW: if (cnt_q == XFER_LAST) begin
        fail_d      = 1'b1;
        fail_code_d = ERR_XFER_TO;
      end
      ST_STOP: begin
        if (cnt_q == XFER_LAST) begin
          fail_d      = 1'b1;
          fail_code_d = ERR_XFER_TO;
        end else if (clk_fe && data_lvl) begin
          fail_d      = 1'b1;
          fail_code_d = ERR_NACK;
        end
      end
      default: ;
    endcase
  end

`ifdef PS2_HOST_TX_RETRY_EN
  assign retry_ok = (fail_code_d != ERR_START_TO) && (retry_q != 2'd2);
`else
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      par_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
      if (fail_d) begin
        cnt_q     <= '0;
        data_oe_q <= 1'b0;
        if (retry_ok) begin
          state_q  <= ST_INHIBIT;
          clk_oe_q <= 1'b1;
          shift_q  <= byte_q;
`ifdef PS2_HOST_TX_RETRY_EN
          retry_q  <= retry_q + 2'd1;
`endif
        end else begin
          state_q  <= ST_ERR;
          clk_oe_q <= 1'b0;
          err_q    <= 1'b1;
          code_q   <= fail_code_d;
        end
      end else begin
        unique case (state_q)
          ST_IDLE: if (tx_valid) begin
            byte_q   <= tx_data;
            shift_q  <= tx_data;
            par_q    <= odd_parity(tx_data);
            cnt_q    <= '0;
            clk_oe_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q  <= '0;
`endif
          end
          ST_INHIBIT: begin
            if (cnt_q == INH_LAST) begin
              state_q   <= ST_REQ;
              clk_oe_q  <= 1'b0;
              data_oe_q <= 1'b1;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_sat;
            end
          end
          ST_REQ: begin
            if (clk_fe) begin
              state_q   <= ST_DATA;
              bit_idx_q <= '0;
              data_oe_q <= ~shift_q[0];
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_sat;
            end
          end
          ST_DATA: begin
            cnt_q <= cnt_sat;
            if (clk_fe) begin
              if (bit_idx_q == 3'd7) begin
                data_oe_q <= ~par_q;
                state_q   <= ST_PARITY;
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
                shift_q   <= shift_q >> 1;
                data_oe_q <= ~shift_q[1];
              end
            end
          end
          ST_PARITY: begin
            cnt_q <= cnt_sat;
            if (clk_fe) begin
              data_oe_q <= 1'b0;
              state_q   <= ST_STOP;
            end
          end
          ST_STOP: begin
            cnt_q <= cnt_sat;
            if (clk_fe) state_q <= ST_ACKW;
          end
          ST_ACKW: begin
            cnt_q <= cnt_sat;
            if (clk_lvl && data_lvl) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
          ST_DONE, ST_ERR: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx_ready    = (state_q == ST_IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign err_code    = code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a scaled-timing PS/2 device model.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 120;
  localparam int unsigned STO  = 3000;
  localparam int unsigned XTO  = 2000;
  localparam int unsigned HALF = 40;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int unsigned RETRY_FRAMES = 3;
`else
  localparam int unsigned RETRY_FRAMES = 1;
`endif

  localparam logic [3:0] RES_DONE  = 4'b1000;
  localparam logic [3:0] RES_START = 4'b0101;
  localparam logic [3:0] RES_XFER  = 4'b0110;
  localparam logic [3:0] RES_NACK  = 4'b0111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_ready;
  logic       ps2_clk_line;
  logic       ps2_data_line;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] err_code;
  logic       bfm_clk_low = 1'b0;
  logic       bfm_data_low = 1'b0;

  assign ps2_clk_line  = ~(ps2_clk_oe | bfm_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | bfm_data_low);

  ps2_host_tx #(
    .INHIBIT_CYC  (INH),
    .START_TO_CYC (STO),
    .XFER_TO_CYC  (XTO),
    .FILT_LEN     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned evt_cyc = 0;
  int unsigned inh_run = 0;
  int unsigned inh_last = 0;
  int unsigned inh_phases = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  act_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Result and inhibit-phase monitors.
  always @(negedge clk) begin
    if (tx_done || tx_err) begin
      act_q.push_back({tx_done, tx_err, err_code});
      evt_cyc = cyc;
    end
    if (ps2_clk_oe) inh_run++;
    else if (inh_run != 0) begin
      inh_last = inh_run;
      inh_phases++;
      inh_run = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int unsigned ones = 0;
    for (int unsigned i = 0; i < 8; i++) if (b[i]) ones++;
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int unsigned t = 0;
    while (!tx_ready && t < 10000) begin @(negedge clk); t++; end
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device model: waits for the request, samples start, then generates nclk
  // clock pulses, reading each bit after the rising edge; ACKs on pulse 11.
  task automatic device_frame(input int unsigned nclk, input bit ack,
                              output logic [10:0] cap, output bit got);
    int unsigned t = 0;
    cap = '0;
    got = 1'b0;
    while (!(ps2_data_line == 1'b0 && ps2_clk_line == 1'b1) && t < INH + 400) begin
      @(negedge clk);
      t++;
    end
    if (!(ps2_data_line == 1'b0 && ps2_clk_line == 1'b1)) begin
      tests++;
      fails++;
      $display("FAIL bfm_request: no host request within %0d cycles", t);
      return;
    end
    got = 1'b1;
    repeat (HALF) @(negedge clk);
    cap[0] = ps2_data_line;
    for (int unsigned i = 1; i <= nclk; i++) begin
      bfm_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      bfm_clk_low = 1'b0;
      if (i <= 10) cap[i] = ps2_data_line;
      if (i == 10 && ack) bfm_data_low = 1'b1;
      if (i == 11) bfm_data_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic wait_result(input string name, input int unsigned budget);
    int unsigned t = 0;
    logic [3:0] e;
    while (act_q.size() == 0 && t < budget) begin @(negedge clk); t++; end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hF;
    if (act_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: no tx_done/tx_err within %0d cycles, expected %0h", name, budget, e);
    end else begin
      check(name, 32'(act_q.pop_front()), 32'(e));
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack);
    logic [10:0] cap;
    bit          got;
    int unsigned ph0;
    int unsigned nfr;
    nfr = ack ? 1 : RETRY_FRAMES;
    ph0 = inh_phases;
    exp_q.push_back(ack ? RES_DONE : RES_NACK);
    send_byte(b);
    for (int unsigned k = 0; k < nfr; k++) begin
      device_frame(11, ack, cap, got);
      if (got) check($sformatf("frame_%02h", b), 32'(cap), 32'(model_frame(b)));
    end
    wait_result($sformatf("result_%02h", b), 2 * XTO);
    @(negedge clk);
    @(negedge clk);
    check("ready_after", 32'(tx_ready), 32'd1);
    check("inhibit_phases", inh_phases - ph0, nfr);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
  } vec_t;

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [10:0] cap;
    bit          got;
    int unsigned c0;
    int unsigned t;
    int unsigned ph0;

    vecs[0] = '{8'hED, 1'b1};
    vecs[1] = '{8'h00, 1'b1};
    vecs[2] = '{8'hFF, 1'b1};
    vecs[3] = '{8'hF4, 1'b1};
    vecs[4] = '{8'hA5, 1'b0};
    vecs[5] = '{8'h01, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_done_err", 32'({tx_done, tx_err, err_code}), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int unsigned v = 0; v < 6; v++) begin
      run_frame(vecs[v].data, vecs[v].ack);
      if (v == 0) check("inhibit_len", inh_last, INH);
    end

    // Device never clocks: start timeout exactly STO cycles after the request
    exp_q.push_back(RES_START);
    send_byte(8'hF4);
    t = 0;
    while (!ps2_data_oe && t < INH + 50) begin @(negedge clk); t++; end
    c0 = cyc;
    wait_result("start_timeout", STO + 100);
    check("start_to_latency", evt_cyc - c0, STO);
    @(negedge clk);
    check("start_to_release", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("start_to_pulse", 32'(tx_err), 32'd0);

    // Device stops after bit 4; tx_valid offered while busy must be dropped
    exp_q.push_back(RES_XFER);
    send_byte(8'h96);
    fork
      begin
        for (int unsigned k = 0; k < RETRY_FRAMES; k++) begin
          device_frame(5, 1'b0, cap, got);
          if (got) check("partial_frame", 32'(cap[5:0]), 32'(model_frame(8'h96) & 11'h03F));
        end
      end
      begin
        repeat (400) @(negedge clk);
        check("ready_while_busy", 32'(tx_ready), 32'd0);
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    wait_result("xfer_timeout", XTO + 500);
    ph0 = inh_phases;
    repeat (INH + 200) @(negedge clk);
    check("no_second_frame", inh_phases - ph0, 0);
    check("idle_after_xfer", 32'({tx_ready, busy, ps2_clk_oe}), 32'b100);

    // Asynchronous reset during DATA, then a clean frame
    send_byte(8'h00);
    device_frame(3, 1'b0, cap, got);
    check("data_phase_drive", 32'({busy, ps2_data_oe}), 32'b11);
    #2 rst = 1'b0;
    #1;
    check("async_rst_release", 32'({ps2_clk_oe, ps2_data_oe, busy}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    run_frame(8'hFA, 1'b1);

    check("no_stray_results", act_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
